// File: rtl/regfile_sequencer_if.sv
// rtl/regfile_sequencer_if.sv - issue, register-file and ALU signals of the register-file sequencer
interface regfile_sequencer_if #(
  parameter int ADDR_W = 3,
  parameter int OPC_W  = 4
);
  logic              instr_valid;
  logic              instr_ready;
  logic [OPC_W-1:0]  instr_opc;
  logic [ADDR_W-1:0] instr_sa;
  logic [ADDR_W-1:0] instr_sb;
  logic [ADDR_W-1:0] instr_dr;
  logic              instr_wb;
  logic [ADDR_W-1:0] sa;
  logic [ADDR_W-1:0] sb;
  logic [ADDR_W-1:0] dr;
  logic              ld;
  logic [OPC_W-1:0]  alu_op;
  logic              alu_start;
  logic              alu_done;
  logic              done;
  logic              err;

  modport master (
    output instr_valid, instr_opc, instr_sa, instr_sb, instr_dr, instr_wb, alu_done,
    input  instr_ready, sa, sb, dr, ld, alu_op, alu_start, done, err
  );

  modport slave (
    input  instr_valid, instr_opc, instr_sa, instr_sb, instr_dr, instr_wb, alu_done,
    output instr_ready, sa, sb, dr, ld, alu_op, alu_start, done, err
  );
endinterface

// File: rtl/regfile_sequencer.sv
// rtl/regfile_sequencer.sv - multi-cycle read/exec/write controller for the 8x8 register file and ALU
// Optional macro REGSEQ_R0_ZERO_EN makes register 0 read-only (write-back to DR==0 suppressed).
module regfile_sequencer #(
  parameter int ADDR_W  = 3,
  parameter int OPC_W   = 4,
  parameter int TIMEOUT = 15
) (
  input logic               clk,
  input logic               rst_n,
  regfile_sequencer_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_READ  = 2'd1,
    S_EXEC  = 2'd2,
    S_WRITE = 2'd3
  } state_t;

  localparam logic [7:0] TIMEOUT_C = 8'(TIMEOUT);

  state_t            state, state_n;
  logic [ADDR_W-1:0] sa_q, sa_n;
  logic [ADDR_W-1:0] sb_q, sb_n;
  logic [ADDR_W-1:0] dr_q, dr_n;
  logic [OPC_W-1:0]  op_q, op_n;
  logic              wb_q, wb_n;
  logic [7:0]        cnt_q, cnt_n;
  logic              ld_q, ld_n;
  logic              start_q, start_n;
  logic              done_q, done_n;
  logic              err_q, err_n;
  logic              wr_en;

`ifdef REGSEQ_R0_ZERO_EN
  assign wr_en = wb_q && (dr_q != '0);
`else
  assign wr_en = wb_q;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= S_IDLE;
      sa_q    <= '0;
      sb_q    <= '0;
      dr_q    <= '0;
      op_q    <= '0;
      wb_q    <= 1'b0;
      cnt_q   <= '0;
      ld_q    <= 1'b0;
      start_q <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state   <= state_n;
      sa_q    <= sa_n;
      sb_q    <= sb_n;
      dr_q    <= dr_n;
      op_q    <= op_n;
      wb_q    <= wb_n;
      cnt_q   <= cnt_n;
      ld_q    <= ld_n;
      start_q <= start_n;
      done_q  <= done_n;
      err_q   <= err_n;
    end
  end

  // Pulse outputs are computed one state ahead so they are registered in the state they belong to.
  always_comb begin
    state_n = state;
    sa_n    = sa_q;
    sb_n    = sb_q;
    dr_n    = dr_q;
    op_n    = op_q;
    wb_n    = wb_q;
    cnt_n   = cnt_q;
    ld_n    = 1'b0;
    start_n = 1'b0;
    done_n  = 1'b0;
    err_n   = err_q;
    case (state)
      S_IDLE: begin
        if (bus.instr_valid) begin
          sa_n    = bus.instr_sa;
          sb_n    = bus.instr_sb;
          dr_n    = bus.instr_dr;
          op_n    = bus.instr_opc;
          wb_n    = bus.instr_wb;
          start_n = 1'b1;
          state_n = S_READ;
        end
      end
      S_READ: begin
        cnt_n   = '0;
        state_n = S_EXEC;
      end
      S_EXEC: begin
        // A result arriving on the timeout cycle still retires normally.
        if (bus.alu_done) begin
          ld_n    = wr_en;
          done_n  = 1'b1;
          state_n = S_WRITE;
        end else begin
          cnt_n = cnt_q + 8'd1;
          if (cnt_n == TIMEOUT_C) begin
            err_n   = 1'b1;
            done_n  = 1'b1;
            state_n = S_IDLE;
          end
        end
      end
      S_WRITE: begin
        state_n = S_IDLE;
      end
      default: begin
        state_n = S_IDLE;
      end
    endcase
  end

  assign bus.instr_ready = (state == S_IDLE);
  assign bus.sa          = sa_q;
  assign bus.sb          = sb_q;
  assign bus.dr          = dr_q;
  assign bus.ld          = ld_q;
  assign bus.alu_op      = op_q;
  assign bus.alu_start   = start_q;
  assign bus.done        = done_q;
  assign bus.err         = err_q;

endmodule
